// File: rtl/mmio_ports.sv
// Memory-mapped board I/O register bank for the CPU data bus: LED register,
// synchronised switches, debounced buttons with sticky edge flags, prescaled tick.
module mmio_ports #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 11,
  parameter int unsigned BASE    = (1 << (ADDR_W - 3)) - 1,
  parameter int          N_BTN   = 4,
  parameter int          N_SW    = 4,
  parameter int          N_LED   = 4,
  parameter int          DB_W    = 16,
  parameter int          PRESC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  input  logic [N_BTN-1:0]  buttons,
  input  logic [N_SW-1:0]   switches,
  output logic [N_LED-1:0]  leds
);

  localparam logic [ADDR_W-4:0] BASE_SEL = (ADDR_W - 3)'(BASE);

  localparam logic [2:0] OFF_LED  = 3'd0;
  localparam logic [2:0] OFF_SW   = 3'd1;
  localparam logic [2:0] OFF_BTN  = 3'd2;
  localparam logic [2:0] OFF_EDGE = 3'd3;
  localparam logic [2:0] OFF_TICK = 3'd4;

  logic              in_win;
  logic              wr_en;
  logic [2:0]        off;

  logic [N_SW-1:0]   sw_s1_reg;
  logic [N_SW-1:0]   sw_s2_reg;
  logic [N_BTN-1:0]  btn_s1_reg;
  logic [N_BTN-1:0]  btn_s2_reg;

  logic [N_BTN-1:0]  btn_level;
  logic [N_BTN-1:0]  btn_rise;

  logic [DATA_W-1:0]  led_reg;
  logic [N_BTN-1:0]   edge_reg;
  logic [N_BTN-1:0]   edge_clr;
  logic [N_BTN-1:0]   edge_next;
  logic [DATA_W-1:0]  tick_reg;
  logic [PRESC_W-1:0] presc_reg;

  logic [DATA_W-1:0] rd_next;
  logic [DATA_W-1:0] rdata_reg;
  logic              hit_reg;

  assign in_win = (addr[ADDR_W-1:3] == BASE_SEL);
  assign wr_en  = wr & in_win;
  assign off    = addr[2:0];

  // Two-flop synchronisers for the raw asynchronous board inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
    end else begin
      sw_s1_reg  <= switches;
      sw_s2_reg  <= sw_s1_reg;
      btn_s1_reg <= buttons;
      btn_s2_reg <= btn_s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_reg;
      logic            stable_reg;
      logic            settle;

      // Input has differed from the stable level for 2^DB_W consecutive cycles
      assign settle = (btn_s2_reg[gi] != stable_reg) && (cnt_reg == {DB_W{1'b1}});

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b0;
        end else if (btn_s2_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (settle) begin
          stable_reg <= btn_s2_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end

      assign btn_level[gi] = stable_reg;
      assign btn_rise[gi]  = settle & btn_s2_reg[gi];
    end
  endgenerate

  always_comb begin
    edge_clr = '0;
    if (wr_en && (off == OFF_EDGE)) begin
      edge_clr = wdata[N_BTN-1:0];
    end
  end

  // A rising edge in the same cycle as a clear keeps the flag set
  assign edge_next = (edge_reg & ~edge_clr) | btn_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg  <= '0;
      edge_reg <= '0;
    end else begin
      edge_reg <= edge_next;
      if (wr_en && (off == OFF_LED)) begin
        led_reg <= wdata;
      end
    end
  end

  // A bus write to TICK takes priority over a prescaler increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg  <= '0;
      presc_reg <= '0;
    end else if (wr_en && (off == OFF_TICK)) begin
      tick_reg  <= wdata;
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PRESC_W'(1);
      if (presc_reg == {PRESC_W{1'b1}}) begin
        tick_reg <= tick_reg + DATA_W'(1);
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (off)
      OFF_LED:  rd_next = led_reg;
      OFF_SW:   rd_next[N_SW-1:0] = sw_s2_reg;
      OFF_BTN:  rd_next[N_BTN-1:0] = btn_level;
      OFF_EDGE: rd_next[N_BTN-1:0] = edge_reg;
      OFF_TICK: rd_next = tick_reg;
      default:  rd_next = '0;
    endcase
  end

  // Registered read path lines up with the data BRAM's one-cycle latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
      hit_reg   <= 1'b0;
    end else begin
      rdata_reg <= in_win ? rd_next : '0;
      hit_reg   <= in_win;
    end
  end

  assign rdata = rdata_reg;
  assign hit   = hit_reg;
  assign leds  = led_reg[N_LED-1:0];

endmodule

// File: tb/tb_mmio_ports.sv
// Scoreboarded bench for mmio_ports: stimulus queues expected read data,
// a negedge monitor pops and compares whenever hit is presented.
module tb_mmio_ports;

  localparam int DW  = 8;
  localparam int AW  = 11;
  localparam int NB  = 4;
  localparam int NS  = 4;
  localparam int NL  = 4;
  localparam int DBW = 4;
  localparam int PW  = 2;
  localparam logic [AW-1:0] WIN = 11'h7F8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          hit;
  logic [NB-1:0] buttons;
  logic [NS-1:0] switches;
  logic [NL-1:0] leds;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_d[$];
  bit         exp_c[$];
  string      exp_n[$];

  mmio_ports #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .N_BTN  (NB),
    .N_SW   (NS),
    .N_LED  (NL),
    .DB_W   (DBW),
    .PRESC_W(PW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .rdata   (rdata),
    .hit     (hit),
    .buttons (buttons),
    .switches(switches),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit c, input string nm);
    exp_d.push_back(d);
    exp_c.push_back(c);
    exp_n.push_back(nm);
  endtask

  task automatic rd(input logic [2:0] o, input logic [7:0] d, input string nm);
    addr = WIN + AW'(o);
    wr   = 1'b0;
    push(d, 1'b1, nm);
    cyc();
    addr = '0;
  endtask

  task automatic wrt(input logic [AW-1:0] a, input logic [7:0] v,
                     input logic [7:0] old, input bit c, input string nm);
    addr  = a;
    wr    = 1'b1;
    wdata = v;
    if (a[AW-1:3] == WIN[AW-1:3]) push(old, c, nm);
    cyc();
    wr   = 1'b0;
    addr = '0;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end else begin
      $display("check %s value=%h ok", nm, act);
    end
  endtask

  // Monitor: every in-window access yields hit; idle cycles must read zero
  always @(negedge clk) begin
    if (rst_n) begin
      if (hit) begin
        checks++;
        if (exp_d.size() == 0) begin
          errors++;
          $display("FAIL unexpected_hit rdata=%h expected=no_access", rdata);
        end else begin
          logic [7:0] d;
          bit         c;
          string      nm;
          d  = exp_d.pop_front();
          c  = exp_c.pop_front();
          nm = exp_n.pop_front();
          if (c && (rdata !== d)) begin
            errors++;
            $display("FAIL %s rdata=%h expected=%h", nm, rdata, d);
          end else begin
            $display("access %s rdata=%h hit=1", nm, rdata);
          end
        end
      end else if (rdata !== 8'h00) begin
        checks++;
        errors++;
        $display("FAIL idle_rdata rdata=%h expected=00", rdata);
      end
    end
  end

  initial begin
    addr     = '0;
    wr       = 1'b0;
    wdata    = '0;
    buttons  = '0;
    switches = 4'b0101;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_leds", {4'b0, leds}, 8'h00);
    chk("rst_hit", {7'b0, hit}, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    cyc(2);

    // LED register and address decode
    wrt(WIN + 11'd0, 8'h0F, 8'h00, 1'b1, "led_wr");
    chk("leds_after_wr", {4'b0, leds}, 8'h0F);
    wrt(11'h3F8, 8'h00, 8'h00, 1'b0, "outside_wr");
    chk("leds_outside_wr", {4'b0, leds}, 8'h0F);
    rd(3'd0, 8'h0F, "led_rd");
    rd(3'd6, 8'h00, "off6_rd");
    wrt(WIN + 11'd6, 8'hFF, 8'h00, 1'b1, "off6_wr");
    rd(3'd6, 8'h00, "off6_after_wr");

    // Switch synchroniser latency
    rd(3'd1, 8'h05, "sw_old");
    switches = 4'b1010;
    addr = WIN + 11'd1;
    push(8'h05, 1'b1, "sw_e1");
    cyc();
    push(8'h05, 1'b1, "sw_e2");
    cyc();
    push(8'h0A, 1'b1, "sw_e3");
    cyc();
    addr = '0;

    // Glitch shorter than the debounce window
    buttons = 4'b0010;
    cyc(9);
    rd(3'd2, 8'h00, "btn_glitch_hi");
    buttons = 4'b0000;
    cyc(20);
    rd(3'd2, 8'h00, "btn_glitch");
    rd(3'd3, 8'h00, "edge_glitch");

    // Held press: level changes on the 18th edge after the input moves
    buttons = 4'b0010;
    cyc(17);
    addr = WIN + 11'd2;
    push(8'h00, 1'b1, "btn_e18");
    cyc();
    push(8'h02, 1'b1, "btn_e19");
    cyc();
    addr = '0;
    rd(3'd3, 8'h02, "edge_set");

    // W1C of bit 1 coincides with the bit 0 rising edge
    buttons = 4'b0011;
    cyc(17);
    wrt(WIN + 11'd3, 8'h02, 8'h02, 1'b1, "edge_race_wr");
    rd(3'd3, 8'h01, "edge_race");
    rd(3'd2, 8'h03, "btn_both");
    wrt(WIN + 11'd3, 8'h01, 8'h01, 1'b1, "edge_w1c");
    rd(3'd3, 8'h00, "edge_clr");

    // Tick wrap and write-over-increment
    wrt(WIN + 11'd4, 8'hFE, 8'h00, 1'b0, "tick_ld");
    cyc(7);
    addr = WIN + 11'd4;
    push(8'hFF, 1'b1, "tick_e8");
    cyc();
    push(8'h00, 1'b1, "tick_wrap");
    cyc();
    addr = '0;
    cyc(2);
    wrt(WIN + 11'd4, 8'h10, 8'h00, 1'b1, "tick_wr_race");
    rd(3'd4, 8'h10, "tick_wr_wins");

    // Build EDGE=3, LED=A5, then reset mid-run
    buttons = 4'b0000;
    cyc(20);
    buttons = 4'b0011;
    cyc(20);
    rd(3'd3, 8'h03, "edge_both");
    wrt(WIN + 11'd0, 8'hA5, 8'h0F, 1'b1, "led_a5");
    chk("leds_a5", {4'b0, leds}, 8'h05);
    addr = WIN + 11'd3;
    push(8'h03, 1'b1, "edge_pre_rst");
    cyc();
    @(negedge clk);
    #1;
    addr  = '0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_leds", {4'b0, leds}, 8'h00);
    chk("async_rst_hit", {7'b0, hit}, 8'h00);
    chk("async_rst_rdata", rdata, 8'h00);
    cyc(2);
    chk("held_rst_leds", {4'b0, leds}, 8'h00);
    chk("held_rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    rd(3'd4, 8'h00, "tick_after_rst");
    rd(3'd0, 8'h00, "led_after_rst");
    rd(3'd3, 8'h00, "edge_after_rst");
    rd(3'd2, 8'h00, "btn_after_rst");
    chk("leds_after_rst", {4'b0, leds}, 8'h00);

    cyc(3);
    chk("pending_reads", 8'(exp_d.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
